seq_rr_arbiter: RTL
===================

// Module: seq_rr_arbiter
// PURPOSE
//   Shares one down-counting step sequencer (STEPS-1 -> ... -> 0, y high on
//   every non-zero step) between NREQ requesters. A round-robin arbiter grants
//   ownership, runs one full sequence per grant and signals completion or abort.
//   Sits between client FSMs and the shared sequencer datapath.
// PARAMETERS
//   NREQ     4   number of requesters (2..8)
//   STATE_W  2   width of step counter
//   STEPS    4   steps per sequence (2..2**STATE_W); first step value = STEPS-1
// PORTS
//   clk    in   1        single clock, rising edge
//   rst    in   1        synchronous reset, active-high
//   req    in   NREQ     level request per client; held until done/abort
//   gnt    out  NREQ     registered one-hot grant; all-zero when idle
//   busy   out  1        registered; high while in RUN
//   step   out  STATE_W  registered current step value; 0 when idle
//   y      out  1        comb; RUN && step!=0
//   done   out  1        comb; RUN && step==0 && req[owner]
//   abort  out  1        comb; RUN && !req[owner]
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, gnt=0, busy=0, step=0, ptr=0; every
//     output low. rst overrides all, including mid-sequence (no done/abort).
//   States: IDLE, RUN. owner = index of the set bit in gnt.
//   IDLE: at edge, if req!=0: winner = first i with req[i]=1, scanning
//     ptr, ptr+1, ... mod NREQ; gnt<=1<<winner, busy<=1, step<=STEPS-1,
//     state<=RUN. If req==0: stay IDLE, all outputs hold reset values.
//   RUN, per edge, in priority order:
//     1. abort (req[owner]=0): state<=IDLE, gnt<=0, busy<=0, step<=0,
//        ptr<=(owner+1) mod NREQ.
//     2. done (step==0): same updates as abort.
//     3. otherwise step<=step-1.
//   Simultaneous abort and step==0: abort wins; done stays low.
//   Latency: req seen in IDLE at edge k -> gnt high after k; gnt stays high for
//     exactly STEPS cycles; y high for the first STEPS-1 of them; done high in
//     the last. Minimum one IDLE cycle (gnt=0) between grants.
//   Fairness: winner never re-granted while another req was high at the
//     arbitration edge. Requests from non-owners are ignored during RUN.
//   ptr wraps NREQ-1 -> 0. step never underflows (leaves RUN at 0).
// CONFIGURATION
//   SEQ_ARB_HOLD_EN defined: at a done edge, if req[owner] still high and no
//     other req bit is high, stay in RUN with the same gnt, step<=STEPS-1,
//     and leave ptr unchanged: back-to-back sequences with no IDLE gap.
//     busy stays high. If another req bit is high, normal release.
//   Not defined: done always returns to IDLE and advances ptr.
// TESTING
//   1. rst=1 two cycles with req=4'b1111 -> gnt=0, busy=0, step=0, y/done/abort=0.
//   2. req=4'b0001 held -> gnt=0001 for 4 cycles, step 3,2,1,0, y=1,1,1,0,
//      done on step 0, then one IDLE cycle (without HOLD_EN), then re-grant.
//   3. req=4'b1111 held -> gnt order 0001,0010,0100,1000,0001, each 4 cycles
//      separated by one gnt=0 cycle.
//   4. req=4'b0100, drop req[2] at step=2 -> abort=1 that cycle, gnt=0 next,
//      done never asserted; then req=4'b0101 -> next grant to client 0.
//   5. Drop req[owner] exactly in step==0 cycle -> abort=1, done=0.
//   6. SEQ_ARB_HOLD_EN, req=4'b0010 held -> gnt continuously 0010, step 3,2,1,0,
//      3,... with no IDLE gap; raise req[0] -> release after done, then grant 0001.

Source files
------------

// File: rtl/seq_rr_arbiter.sv
// seq_rr_arbiter
//   Round-robin arbiter that hands ownership of one shared down-counting step
//   sequencer to one of NREQ requesters. A grant runs one full sequence
//   (STEPS-1 down to 0). The grant ends with done, or early with abort when
//   the owner drops its request.
//
//   Ports
//     clk    in   rising-edge clock
//     rst    in   synchronous reset, active-high
//     req    in   [NREQ]     level request per client
//     gnt    out  [NREQ]     registered one-hot grant, zero when idle
//     busy   out             registered, high while a sequence runs
//     step   out  [STATE_W]  registered current step, zero when idle
//     y      out             comb, running and step != 0
//     done   out             comb, running, step == 0 and owner still requesting
//     abort  out             comb, running and owner request dropped
//
//   Build option
//     SEQ_ARB_HOLD_EN : if the owner is the only requester at a done edge,
//                       restart its sequence immediately with no idle gap.

module seq_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned STATE_W = 2,
  parameter int unsigned STEPS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [STATE_W-1:0] step,
  output logic               y,
  output logic               done,
  output logic               abort
);

  localparam int unsigned        PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [STATE_W-1:0] STEP_FIRST = STATE_W'(STEPS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [STATE_W-1:0] step_q, step_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   ptr_rel;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic               req_own;
  logic               hold_c;

  // Index of the granted client (gnt_q is one-hot or zero).
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) owner = PTR_W'(i);
    end
  end

  // Round-robin scan starting at ptr_q; first requester found wins.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PTR_W'((32'(ptr_q) + k) % NREQ);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign req_own = |(req & gnt_q);
  assign ptr_rel = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;

  // Back-to-back restart only when the owner is the sole requester.
`ifdef SEQ_ARB_HOLD_EN
  assign hold_c = req_own && ((req & ~gnt_q) == '0);
`else
  assign hold_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      step_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    step_d  = step_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_RUN;
          gnt_d   = NREQ'(1) << winner;
          busy_d  = 1'b1;
          step_d  = STEP_FIRST;
        end
      end
      S_RUN: begin
        // Abort and done share the release path; abort takes priority
        // because done is qualified by req_own.
        if (!req_own || (step_q == '0)) begin
          if (hold_c) begin
            step_d = STEP_FIRST;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            step_d  = '0;
            ptr_d   = ptr_rel;
          end
        end else begin
          step_d = step_q - 1'b1;
        end
      end
    endcase
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign step  = step_q;
  assign y     = (state_q == S_RUN) && (step_q != '0);
  assign done  = (state_q == S_RUN) && (step_q == '0) && req_own;
  assign abort = (state_q == S_RUN) && !req_own;

endmodule
